// File: rtl/msfsm_transition_scheduler.sv
// Round-robin transition scheduler for a Mealy MSFSM ensemble: grants one
// enabled+requested transition at a time, holds it until ack, aborts on timeout.
module msfsm_transition_scheduler #(
   parameter int unsigned N_TRANS    = 9,
   parameter int unsigned TIMEOUT    = 16,
   parameter int unsigned SETTLE_CYC = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N_TRANS-1:0] req,
   input  logic [N_TRANS-1:0] en,
   input  logic               ack,
   input  logic               clr_err,
   output logic [N_TRANS-1:0] fire,
   output logic               busy,
   output logic               err,
   output logic [15:0]        fire_cnt
);

   localparam int unsigned PTR_W  = $clog2(N_TRANS);
   localparam int unsigned TCNT_W = $clog2(TIMEOUT);
   localparam int unsigned SCNT_W = 4;
   localparam int unsigned CNT_W  = 16;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SETTLE} state_t;

   state_t             state, state_nx;
   logic [PTR_W-1:0]   ptr, ptr_nx, ptr_adv, gidx, gidx_nx, sel_idx;
   logic [TCNT_W-1:0]  tcnt, tcnt_nx;
   logic [SCNT_W-1:0]  scnt, scnt_nx;
   logic [N_TRANS-1:0] cand, fire_nx;
   logic [CNT_W-1:0]   fire_cnt_nx;
   logic               err_nx, busy_nx, sel_vld, timeout_hit;
   int unsigned        scan_idx;

   assign cand        = req & en;
   assign timeout_hit = (tcnt == TCNT_W'(TIMEOUT - 1));
   assign ptr_adv     = (gidx == PTR_W'(N_TRANS - 1)) ? '0 : gidx + 1'b1;

   // First candidate at or above ptr, wrapping at N_TRANS-1.
   always_comb begin
      sel_vld  = 1'b0;
      sel_idx  = '0;
      scan_idx = 0;
      for (int unsigned k = 0; k < N_TRANS; k++) begin
         scan_idx = 32'(ptr) + k;
         if (scan_idx >= N_TRANS) scan_idx = scan_idx - N_TRANS;
         if (!sel_vld && cand[PTR_W'(scan_idx)]) begin
            sel_vld = 1'b1;
            sel_idx = PTR_W'(scan_idx);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:   if (sel_vld) state_nx = S_WAIT;
         S_WAIT:   if (ack || timeout_hit) state_nx = S_SETTLE;
         S_SETTLE: if (scnt <= SCNT_W'(1)) state_nx = S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
   end

   // Datapath next values; ack has priority over timeout, timeout over clr_err.
   always_comb begin
      fire_nx     = fire;
      gidx_nx     = gidx;
      ptr_nx      = ptr;
      tcnt_nx     = tcnt;
      scnt_nx     = scnt;
      fire_cnt_nx = fire_cnt;
      err_nx      = err;
      if (clr_err) err_nx = 1'b0;
      case (state)
         S_IDLE: begin
            if (sel_vld) begin
               fire_nx = N_TRANS'(1) << sel_idx;
               gidx_nx = sel_idx;
               tcnt_nx = '0;
            end
         end
         S_WAIT: begin
            if (ack) begin
               fire_nx     = '0;
               fire_cnt_nx = fire_cnt + 16'd1;
               ptr_nx      = ptr_adv;
               scnt_nx     = SCNT_W'(SETTLE_CYC);
            end else if (timeout_hit) begin
               fire_nx = '0;
               err_nx  = 1'b1;
               ptr_nx  = ptr_adv;
               scnt_nx = SCNT_W'(SETTLE_CYC);
            end else begin
               tcnt_nx = tcnt + 1'b1;
            end
         end
         S_SETTLE: begin
            fire_nx = '0;
            scnt_nx = scnt - 1'b1;
         end
         default: fire_nx = '0;
      endcase
      busy_nx = (state_nx != S_IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fire     <= '0;
         busy     <= 1'b0;
         err      <= 1'b0;
         fire_cnt <= '0;
         ptr      <= '0;
         gidx     <= '0;
         tcnt     <= '0;
         scnt     <= '0;
      end else begin
         fire     <= fire_nx;
         busy     <= busy_nx;
         err      <= err_nx;
         fire_cnt <= fire_cnt_nx;
         ptr      <= ptr_nx;
         gidx     <= gidx_nx;
         tcnt     <= tcnt_nx;
         scnt     <= scnt_nx;
      end
   end

endmodule

// File: tb/tb_msfsm_transition_scheduler.sv
// Bench for msfsm_transition_scheduler: grant table plus hand sequences for
// round-robin sweep, timeout, ack/timeout collision and mid-WAIT reset.
module tb_msfsm_transition_scheduler;

   localparam int unsigned N  = 9;
   localparam int unsigned TO = 16;

   logic         clk = 1'b0;
   logic         reset;
   logic [N-1:0] req, en;
   logic         ack, clr_err;
   logic [N-1:0] fire;
   logic         busy, err;
   logic [15:0]  fire_cnt;

   int checks   = 0;
   int failures = 0;
   logic [N-1:0] exp_q[$];

   typedef struct {
      logic [N-1:0] req;
      logic [N-1:0] en;
      int           ack_wait;
      bit           drop;
      logic [N-1:0] exp_fire;
      int           exp_cnt;
   } vec_t;
   vec_t vecs[8];

   always #5 clk = ~clk;

   msfsm_transition_scheduler #(.N_TRANS(N), .TIMEOUT(TO), .SETTLE_CYC(1)) dut (
      .clk(clk), .reset(reset), .req(req), .en(en), .ack(ack), .clr_err(clr_err),
      .fire(fire), .busy(busy), .err(err), .fire_cnt(fire_cnt)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_grant(output int cyc, output bit ok);
      ok  = 1'b0;
      cyc = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         cyc++;
         if (fire != '0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         failures++;
         $display("FAIL grant_wait: no fire after %0d cycles", cyc);
      end
   endtask

   task automatic pop_compare(input string name);
      logic [N-1:0] e;
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL %s: got grant %0h expected none", name, fire);
      end else begin
         e = exp_q.pop_front();
         check(name, 32'(fire), 32'(e));
      end
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (busy && n < 40) begin
         n++;
         @(negedge clk);
      end
      if (busy) begin
         checks++;
         failures++;
         $display("FAIL idle_wait: busy still 1 after %0d cycles, expected 0", n);
      end
   endtask

   initial begin
      int cyc, n, hi, busy_n;
      bit ok;

      vecs[0] = '{req: 9'h004, en: 9'h004, ack_wait: 1, drop: 1'b0, exp_fire: 9'h004, exp_cnt: 1};
      vecs[1] = '{req: 9'h1FF, en: 9'h100, ack_wait: 2, drop: 1'b1, exp_fire: 9'h100, exp_cnt: 2};
      vecs[2] = '{req: 9'h1FF, en: 9'h1FF, ack_wait: 0, drop: 1'b0, exp_fire: 9'h001, exp_cnt: 3};
      vecs[3] = '{req: 9'h003, en: 9'h003, ack_wait: 0, drop: 1'b0, exp_fire: 9'h002, exp_cnt: 4};
      vecs[4] = '{req: 9'h003, en: 9'h003, ack_wait: 0, drop: 1'b0, exp_fire: 9'h001, exp_cnt: 5};
      vecs[5] = '{req: 9'h0F0, en: 9'h1FF, ack_wait: 0, drop: 1'b0, exp_fire: 9'h010, exp_cnt: 6};
      vecs[6] = '{req: 9'h1FF, en: 9'h021, ack_wait: 0, drop: 1'b0, exp_fire: 9'h020, exp_cnt: 7};
      vecs[7] = '{req: 9'h1FF, en: 9'h021, ack_wait: 0, drop: 1'b0, exp_fire: 9'h001, exp_cnt: 8};

      reset = 1'b0; req = '0; en = '0; ack = 1'b0; clr_err = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_fire", 32'(fire), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_err", 32'(err), 32'h0);
      check("rst_cnt", 32'(fire_cnt), 32'h0);
      reset = 1'b1;

      // Grant table: fire value, hold length, busy length and count per entry.
      for (int i = 0; i < 8; i++) begin
         req = vecs[i].req;
         en  = vecs[i].en;
         exp_q.push_back(vecs[i].exp_fire);
         wait_grant(cyc, ok);
         if (!ok) continue;
         pop_compare($sformatf("vec%0d_fire", i));
         hi = 1;
         busy_n = 1;
         if (vecs[i].drop) begin
            req = '0;
            en  = '0;
         end
         for (int k = 0; k < vecs[i].ack_wait; k++) begin
            @(negedge clk);
            if (fire == vecs[i].exp_fire) hi++;
            if (busy) busy_n++;
         end
         ack = 1'b1; req = '0; en = '0;
         @(negedge clk);
         ack = 1'b0;
         check($sformatf("vec%0d_fire_drop", i), 32'(fire), 32'h0);
         check($sformatf("vec%0d_cnt", i), 32'(fire_cnt), 32'(vecs[i].exp_cnt));
         check($sformatf("vec%0d_hold", i), 32'(hi), 32'(vecs[i].ack_wait + 1));
         wait_idle(n);
         busy_n += n;
         check($sformatf("vec%0d_busy_len", i), 32'(busy_n), 32'(vecs[i].ack_wait + 2));
      end
      check("table_err", 32'(err), 32'h0);

      // Round-robin sweep with ack tied high, starting from a fresh reset.
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      check("rr_cnt_reset", 32'(fire_cnt), 32'h0);
      req = 9'h1FF; en = 9'h1FF; ack = 1'b1;
      for (int g = 0; g < 10; g++) exp_q.push_back(N'(1) << (g % N));
      for (int g = 0; g < 10; g++) begin
         wait_grant(cyc, ok);
         if (!ok) break;
         pop_compare($sformatf("rr%0d_fire", g));
         if (g > 0) check($sformatf("rr%0d_period", g), 32'(cyc), 32'd3);
         if (g == 9) check("rr_cnt_sweep", 32'(fire_cnt), 32'd9);
      end
      req = '0; en = '0;
      @(negedge clk);
      ack = 1'b0;
      wait_idle(n);
      check("rr_cnt_final", 32'(fire_cnt), 32'd10);

      // Timeout without ack: ptr=1, so t1 is granted.
      req = 9'h002; en = 9'h002;
      exp_q.push_back(9'h002);
      wait_grant(cyc, ok);
      pop_compare("to_fire");
      req = '0; en = '0;
      hi = 1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (fire == '0) break;
         hi++;
      end
      check("to_fire_len", 32'(hi), 32'(TO));
      check("to_err", 32'(err), 32'h1);
      check("to_cnt", 32'(fire_cnt), 32'd10);
      wait_idle(n);

      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      check("clr_err", 32'(err), 32'h0);

      // Ack on the exact cycle the timeout would fire: ack wins.
      req = 9'h006; en = 9'h006;
      exp_q.push_back(9'h004);
      wait_grant(cyc, ok);
      pop_compare("coll_fire");
      req = '0; en = '0;
      repeat (TO - 1) @(negedge clk);
      check("coll_fire_held", 32'(fire), 32'h004);
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      check("coll_fire_drop", 32'(fire), 32'h0);
      check("coll_err", 32'(err), 32'h0);
      check("coll_cnt", 32'(fire_cnt), 32'd11);
      wait_idle(n);

      // Raise err again, then reset in the middle of a WAIT.
      req = 9'h010; en = 9'h010;
      exp_q.push_back(9'h010);
      wait_grant(cyc, ok);
      pop_compare("to2_fire");
      req = '0; en = '0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (fire == '0) break;
      end
      check("to2_err", 32'(err), 32'h1);
      wait_idle(n);

      req = 9'h080; en = 9'h080;
      exp_q.push_back(9'h080);
      wait_grant(cyc, ok);
      pop_compare("mid_fire");
      req = '0; en = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      check("async_fire", 32'(fire), 32'h0);
      check("async_busy", 32'(busy), 32'h0);
      check("async_err", 32'(err), 32'h0);
      check("async_cnt", 32'(fire_cnt), 32'h0);
      @(negedge clk);
      reset = 1'b1;
      req = 9'h021; en = 9'h021;
      exp_q.push_back(9'h001);
      wait_grant(cyc, ok);
      pop_compare("post_rst_fire");
      ack = 1'b1; req = '0; en = '0;
      @(negedge clk);
      ack = 1'b0;
      check("post_rst_cnt", 32'(fire_cnt), 32'd1);
      wait_idle(n);
      check("sb_empty", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
